uart_load_sequencer: RTL and testbench

- Receives ASCII hex lines from the UART receiver, assembles 32-bit words and writes them sequentially into SRAM port s1.
- The line format matches what the dump path emits: `LH LH LH LH<LF>`, byte 0 first, low nibble before high nibble within each byte.
- Sits between the RS-232 RX block and the camera frame SRAM, so host images and test patterns can be preloaded.
- Publishes `last_addr` for the dump path.

---
 rtl/uart_load_pkg.sv | 25 ++
 rtl/hex_ascii_decode.sv | 21 ++
 rtl/uart_load_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_uart_load_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_load_pkg.sv
// Shared widths, FSM state encodings and ASCII constants for the UART hex loader.
package uart_load_pkg;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WCNT_W  = 19;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned NIBC_W  = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_RECV   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SKIP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE0 = 3'd3;
    localparam logic [STATE_W-1:0] ST_WRITE1 = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_CR = 8'h0d;
    localparam logic [7:0] ASC_LF = 8'h0a;

    localparam logic [NIBC_W-1:0] NIB_PER_WORD = 4'd8;
    localparam logic [ERR_W-1:0]  ERR_MAX      = 8'hff;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' to a nibble.
module hex_ascii_decode (
    input  logic [7:0] ch,
    output logic [3:0] nibble_c,
    output logic       is_hex_c
);

    always_comb begin
        nibble_c = 4'd0;
        is_hex_c = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble_c = ch[3:0];
            is_hex_c = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // Letters sit at 0x?1..0x?6 in both cases, so +9 gives 10..15.
            nibble_c = ch[3:0] + 4'd9;
            is_hex_c = 1'b1;
        end
    end

endmodule

// File: rtl/uart_load_sequencer.sv
// Assembles ASCII hex lines from the UART into 32-bit words and writes them to SRAM port s1.
// Optional byte echo to the UART transmitter is built when UART_LOAD_ECHO_EN is defined.
module uart_load_sequencer
    import uart_load_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_MAX_ADDR = 18'h3ffff
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_kick,
    output logic              load_done,
    output logic              s1_WE,
    output logic [ADDR_W-1:0] s1_Addr,
    output logic [DATA_W-1:0] s1_WD,
    input  logic              rs_rx_valid,
    input  logic [7:0]        rs_rx_data,
    output logic [ADDR_W-1:0] last_addr,
    output logic [WCNT_W-1:0] word_count,
    output logic [ERR_W-1:0]  err_count
`ifdef UART_LOAD_ECHO_EN
    ,
    output logic              rs_tx_start,
    output logic [7:0]        rs_tx_data,
    input  logic              rs_tx_status
`endif
);

    logic [STATE_W-1:0] state, state_nxt;
    logic               kick_q;
    logic [NIBC_W-1:0]  nib_cnt, nib_cnt_nxt;
    logic [DATA_W-1:0]  asm_word, asm_word_nxt;
    logic               we_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wd_nxt;
    logic               done_nxt;
    logic [ADDR_W-1:0]  last_nxt;
    logic [WCNT_W-1:0]  wcnt_nxt;
    logic [ERR_W-1:0]   err_nxt;
    logic [ERR_W-1:0]   err_inc_c;
    logic [3:0]         nibble_c;
    logic               is_hex_c;
    logic               kick_rise_c;
`ifdef UART_LOAD_ECHO_EN
    logic               tx_start_nxt;
    logic [7:0]         tx_data_nxt;
`endif

    hex_ascii_decode u_hex (
        .ch       (rs_rx_data),
        .nibble_c (nibble_c),
        .is_hex_c (is_hex_c)
    );

    assign kick_rise_c = load_kick & ~kick_q;
    assign err_inc_c   = (err_count == ERR_MAX) ? err_count : err_count + 8'd1;

    // Next-state and next-output computation.
    always_comb begin
        state_nxt    = state;
        nib_cnt_nxt  = nib_cnt;
        asm_word_nxt = asm_word;
        we_nxt       = s1_WE;
        addr_nxt     = s1_Addr;
        wd_nxt       = s1_WD;
        done_nxt     = load_done;
        last_nxt     = last_addr;
        wcnt_nxt     = word_count;
        err_nxt      = err_count;
`ifdef UART_LOAD_ECHO_EN
        tx_start_nxt = 1'b0;
        tx_data_nxt  = rs_tx_data;
`endif

        case (state)
            ST_IDLE, ST_DONE: begin
                if (kick_rise_c) begin
                    addr_nxt     = '0;
                    wcnt_nxt     = '0;
                    err_nxt      = '0;
                    nib_cnt_nxt  = '0;
                    asm_word_nxt = '0;
                    done_nxt     = 1'b0;
                    state_nxt    = ST_RECV;
                end
            end
            ST_RECV: begin
                if (rs_rx_valid) begin
                    if (is_hex_c) begin
                        if (nib_cnt == NIB_PER_WORD) begin
                            err_nxt   = err_inc_c;
                            state_nxt = ST_SKIP;
                        end else begin
                            asm_word_nxt[{nib_cnt[2:0], 2'b00} +: 4] = nibble_c;
                            nib_cnt_nxt = nib_cnt + 4'd1;
                        end
                    end else if (rs_rx_data == ASC_SP || rs_rx_data == ASC_CR) begin
                        state_nxt = ST_RECV;
                    end else if (rs_rx_data == ASC_LF) begin
                        if (nib_cnt == NIB_PER_WORD) begin
                            wd_nxt    = asm_word;
                            we_nxt    = 1'b0;
                            state_nxt = ST_WRITE0;
                        end else if (nib_cnt == 4'd0) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            err_nxt     = err_inc_c;
                            nib_cnt_nxt = '0;
                        end
                    end else begin
                        err_nxt   = err_inc_c;
                        state_nxt = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (rs_rx_valid && rs_rx_data == ASC_LF) begin
                    nib_cnt_nxt = '0;
                    state_nxt   = ST_RECV;
                end
            end
            ST_WRITE0: begin
                we_nxt    = 1'b1;
                state_nxt = ST_WRITE1;
            end
            ST_WRITE1: begin
                last_nxt    = s1_Addr;
                wcnt_nxt    = word_count + 19'd1;
                nib_cnt_nxt = '0;
                if (s1_Addr == P_MAX_ADDR) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    addr_nxt  = s1_Addr + 18'd1;
                    state_nxt = ST_RECV;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

`ifdef UART_LOAD_ECHO_EN
        // Echo is best-effort: a busy transmitter simply drops the byte.
        if ((state == ST_RECV || state == ST_SKIP) && rs_rx_valid && !rs_tx_status) begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = rs_rx_data;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            kick_q     <= 1'b0;
            nib_cnt    <= '0;
            asm_word   <= '0;
            s1_WE      <= 1'b1;
            s1_Addr    <= '0;
            s1_WD      <= '0;
            load_done  <= 1'b0;
            last_addr  <= '0;
            word_count <= '0;
            err_count  <= '0;
`ifdef UART_LOAD_ECHO_EN
            rs_tx_start <= 1'b0;
            rs_tx_data  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            kick_q     <= load_kick;
            nib_cnt    <= nib_cnt_nxt;
            asm_word   <= asm_word_nxt;
            s1_WE      <= we_nxt;
            s1_Addr    <= addr_nxt;
            s1_WD      <= wd_nxt;
            load_done  <= done_nxt;
            last_addr  <= last_nxt;
            word_count <= wcnt_nxt;
            err_count  <= err_nxt;
`ifdef UART_LOAD_ECHO_EN
            rs_tx_start <= tx_start_nxt;
            rs_tx_data  <= tx_data_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_load_sequencer.sv
// Self-checking bench for uart_load_sequencer: directed cases plus random lines against a line-level model.
module tb_uart_load_sequencer;

    localparam logic [17:0] MAX_A = 18'h3;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_kick;
    logic        load_done;
    logic        s1_WE;
    logic [17:0] s1_Addr;
    logic [31:0] s1_WD;
    logic        rs_rx_valid;
    logic [7:0]  rs_rx_data;
    logic [17:0] last_addr;
    logic [18:0] word_count;
    logic [7:0]  err_count;
`ifdef UART_LOAD_ECHO_EN
    logic        rs_tx_start;
    logic [7:0]  rs_tx_data;
    logic        rs_tx_status;
    logic [7:0]  tx_q[$];
`endif

    int passed = 0;
    int total  = 0;

    logic [7:0]  line_q[$];
    logic [49:0] exp_q[$];
    logic [49:0] obs_q[$];
    int          we_long = 0;
    bit          we_prev = 1'b0;

    logic [17:0] m_addr;
    logic [17:0] m_last;
    int          m_wc;
    int          m_ec;
    bit          m_done;
    bit          m_active;

    uart_load_sequencer #(.P_MAX_ADDR(MAX_A)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_kick   (load_kick),
        .load_done   (load_done),
        .s1_WE       (s1_WE),
        .s1_Addr     (s1_Addr),
        .s1_WD       (s1_WD),
        .rs_rx_valid (rs_rx_valid),
        .rs_rx_data  (rs_rx_data),
        .last_addr   (last_addr),
        .word_count  (word_count),
        .err_count   (err_count)
`ifdef UART_LOAD_ECHO_EN
        ,
        .rs_tx_start (rs_tx_start),
        .rs_tx_data  (rs_tx_data),
        .rs_tx_status(rs_tx_status)
`endif
    );

    always #5 clk = ~clk;

    // Observe SRAM writes (and echo pulses) away from the active edge.
    always @(negedge clk) begin
        if (s1_WE === 1'b0) begin
            obs_q.push_back({s1_Addr, s1_WD});
            if (we_prev) we_long++;
        end
        we_prev = (s1_WE === 1'b0);
`ifdef UART_LOAD_ECHO_EN
        if (rs_tx_start === 1'b1) tx_q.push_back(rs_tx_data);
`endif
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexch(input int v, input bit up);
        if (v < 10) return 8'(48 + v);
        return up ? 8'(55 + v) : 8'(87 + v);
    endfunction

    task automatic set_line(input string s);
        line_q.delete();
        for (int i = 0; i < s.len(); i++) line_q.push_back(8'(s[i]));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rs_rx_valid = 1'b1;
        rs_rx_data  = b;
        @(negedge clk);
        rs_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bytes();
        foreach (line_q[i]) send_byte(line_q[i]);
    endtask

    task automatic kick();
        @(negedge clk);
        load_kick = 1'b1;
        @(negedge clk);
        load_kick = 1'b0;
    endtask

    task automatic model_reset();
        m_addr = '0; m_wc = 0; m_ec = 0; m_done = 1'b0; m_active = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Line-level reference: classify the whole line, then apply its effect.
    task automatic model_line();
        int cnt; bit bad; logic [31:0] w; int v;
        if (!m_active) return;
        cnt = 0; bad = 1'b0; w = '0;
        foreach (line_q[i]) begin
            if (line_q[i] == 8'h20 || line_q[i] == 8'h0d) continue;
            v = hexval(line_q[i]);
            if (v < 0) bad = 1'b1;
            else begin
                if (cnt < 8) w = w | (32'(v) << (4 * cnt));
                cnt++;
            end
        end
        if (bad || cnt > 8 || (cnt > 0 && cnt < 8)) begin
            if (m_ec < 255) m_ec++;
        end else if (cnt == 0) begin
            m_active = 1'b0; m_done = 1'b1;
        end else begin
            exp_q.push_back({m_addr, w});
            m_wc++;
            m_last = m_addr;
            if (m_addr == MAX_A) begin
                m_active = 1'b0; m_done = 1'b1;
            end else m_addr = m_addr + 18'd1;
        end
    endtask

    task automatic send_line(input string s);
        set_line(s);
        send_bytes();
        send_byte(8'h0a);
        model_line();
    endtask

    task automatic gen_line();
        int kind, n, badpos;
        string bad = "Gxz-:";
        line_q.delete();
        kind   = int'($urandom_range(0, 9));
        n      = (kind == 1) ? int'($urandom_range(1, 7)) : (kind == 2) ? 9 : 8;
        badpos = (kind == 0) ? int'($urandom_range(0, 7)) : -1;
        for (int i = 0; i < n; i++) begin
            if (i == badpos) line_q.push_back(8'(bad[int'($urandom_range(0, 4))]));
            line_q.push_back(hexch(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1))));
            if ((i % 2 == 1) && ($urandom_range(0, 1) == 1)) line_q.push_back(8'h20);
        end
        if ($urandom_range(0, 3) == 0) line_q.push_back(8'h0d);
    endtask

    task automatic compare_load(input string tag);
        repeat (4) @(negedge clk);
        check({tag, ".nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < obs_q.size()) check({tag, ".write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        check({tag, ".word_count"}, 64'(word_count), 64'(m_wc));
        check({tag, ".err_count"},  64'(err_count),  64'(m_ec));
        check({tag, ".load_done"},  64'(load_done),  64'(m_done));
        check({tag, ".last_addr"},  64'(last_addr),  64'(m_last));
        check({tag, ".we_width"},   64'(we_long),    64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".s1_WE"},      64'(s1_WE),      64'd1);
        check({tag, ".s1_Addr"},    64'(s1_Addr),    64'd0);
        check({tag, ".s1_WD"},      64'(s1_WD),      64'd0);
        check({tag, ".load_done"},  64'(load_done),  64'd0);
        check({tag, ".last_addr"},  64'(last_addr),  64'd0);
        check({tag, ".word_count"}, 64'(word_count), 64'd0);
        check({tag, ".err_count"},  64'(err_count),  64'd0);
    endtask

    initial begin
        reset = 1'b1; load_kick = 1'b0; rs_rx_valid = 1'b0; rs_rx_data = 8'h00;
`ifdef UART_LOAD_ECHO_EN
        rs_tx_status = 1'b0;
`endif
        m_last = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single line with WE/address timing around the LF strobe.
        kick();
        model_reset();
        set_line("78 56 34 12");
        send_bytes();
        check("single.addr_setup", 64'(s1_Addr), 64'd0);
        @(negedge clk);
        rs_rx_valid = 1'b1; rs_rx_data = 8'h0a;
        @(negedge clk);
        rs_rx_valid = 1'b0;
        check("single.we_low",  64'(s1_WE),   64'd0);
        check("single.wd",      64'(s1_WD),   64'h21436587);
        check("single.addr_t1", 64'(s1_Addr), 64'd0);
        @(negedge clk);
        check("single.we_high", 64'(s1_WE),   64'd1);
        check("single.addr_t2", 64'(s1_Addr), 64'd0);
        @(negedge clk);
        check("single.addr_t3", 64'(s1_Addr), 64'd1);
        check("single.wc",      64'(word_count), 64'd1);
        model_line();
        repeat (2) @(negedge clk);
        send_line("");
        compare_load("single");

        // Lowercase hex with CR LF endings, then an empty line.
        kick();
        model_reset();
        send_line("de ad be ef\r");
        send_line("0a 1b 2c 3d\r");
        send_line("ff ee dd cc\r");
        send_line("");
        compare_load("lower");
        check("lower.addr_hold", 64'(s1_Addr), 64'd3);

        // Rejected lines, then a good one lands at address 0.
        kick();
        model_reset();
        send_line("12 3G 00 00");
        send_line("12 34");
        check("bad.nowrite", 64'(obs_q.size()), 64'd0);
        send_line("11 22 33 44");
        send_line("");
        compare_load("bad");

        // Address end: writes stop at MAX_A and later lines are ignored.
        kick();
        model_reset();
        for (int i = 0; i < 6; i++) send_line("5a a5 5a a5");
        compare_load("addr_end");
        check("addr_end.addr", 64'(s1_Addr), 64'(MAX_A));

        // Kick and byte in the same cycle: the byte must be dropped.
        @(negedge clk);
        load_kick = 1'b1; rs_rx_valid = 1'b1; rs_rx_data = 8'h31;
        @(negedge clk);
        load_kick = 1'b0; rs_rx_valid = 1'b0;
        model_reset();
        send_line("00 00 00 00");
        send_line("");
        compare_load("kick_byte");

        // Error counter saturation.
        kick();
        model_reset();
        for (int i = 0; i < 260; i++) send_line("1");
        send_line("");
        compare_load("err_sat");

        // Random loads.
        for (int l = 0; l < 6; l++) begin
            kick();
            model_reset();
            for (int k = 0; k < 6; k++) begin
                gen_line();
                send_bytes();
                send_byte(8'h0a);
                model_line();
            end
            send_line("");
            compare_load("random");
        end

        // Reset asserted during WRITE0.
        kick();
        model_reset();
        set_line("99 88 77 66");
        send_bytes();
        @(negedge clk);
        rs_rx_valid = 1'b1; rs_rx_data = 8'h0a;
        @(negedge clk);
        rs_rx_valid = 1'b0;
        check("rst_mid.we_low", 64'(s1_WE), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid");
        reset = 1'b0;
        m_last = '0;
        obs_q.delete();
        set_line("01 02 03 04");
        send_bytes();
        send_byte(8'h0a);
        repeat (4) @(negedge clk);
        check("rst_mid.idle_nowrite", 64'(obs_q.size()), 64'd0);
        check("rst_mid.idle_wc", 64'(word_count), 64'd0);
        kick();
        model_reset();
        send_line("01 02 03 04");
        send_line("");
        compare_load("after_rst");

`ifdef UART_LOAD_ECHO_EN
        // Echo with TX idle, then with TX busy.
        kick();
        model_reset();
        rs_tx_status = 1'b0;
        tx_q.delete();
        send_byte(8'h41);
        send_byte(8'h35);
        check("echo.count", 64'(tx_q.size()), 64'd2);
        if (tx_q.size() == 2) begin
            check("echo.byte0", 64'(tx_q[0]), 64'h41);
            check("echo.byte1", 64'(tx_q[1]), 64'h35);
        end
        set_line(" 00 00 00");
        send_bytes();
        send_byte(8'h0a);
        set_line("A5 00 00 00");
        model_line();
        repeat (2) @(negedge clk);
        rs_tx_status = 1'b1;
        tx_q.delete();
        send_line("12 34 56 78");
        check("echo.busy_none", 64'(tx_q.size()), 64'd0);
        send_line("");
        compare_load("echo");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
